// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache geometry helpers, arbiter states and command bit positions
package cache_pkg;

    function automatic int calc_set_index(input int cache_bytes, input int block_bytes,
                                          input int ways);
        return $clog2(cache_bytes / (block_bytes * ways));
    endfunction

    function automatic int calc_way_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    typedef enum logic [2:0] {
        ST_DRAIN = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_BUSY  = 3'd3,
        ST_RESP  = 3'd4
    } lru_arb_state_e;

    localparam int CMD_FOUND   = 0;
    localparam int CMD_UPDATED = 1;
    localparam int CMD_REPLACE = 2;
    localparam int CMD_W       = 3;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_id,
    output logic          any
);

    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[IW'((int'(ptr) + i) % N)]) begin
                any      = 1'b1;
                grant_id = IW'((int'(ptr) + i) % N);
            end
        end
        if (any) begin
            grant = N'(1) << grant_id;
        end
    end

endmodule

// File: rtl/lru_update_arbiter.sv
// rtl/lru_update_arbiter.sv - round-robin sharing of one LRU engine among per-core controllers
module lru_update_arbiter
    import cache_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int WAY             = 4,
    parameter int BLOCK_SIZE_BYTE = 16,
    parameter int CACHE_SIZE_BYTE = 32768,
    parameter int SET_INDEX       = calc_set_index(CACHE_SIZE_BYTE, BLOCK_SIZE_BYTE, WAY),
    parameter int TIMEOUT         = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*SET_INDEX-1:0] req_index,
    input  logic [NUM_REQ*5-1:0]         req_way_index,
    input  logic [NUM_REQ-1:0]           req_found,
    input  logic [NUM_REQ-1:0]           req_updated,
    input  logic [NUM_REQ-1:0]           req_replace,
    output logic [NUM_REQ-1:0]           ack,
    output logic [4:0]                   rsp_replace_index,
    output logic                         rsp_block_replace,
    output logic                         rsp_timeout,
    output logic                         err_sticky,
    output logic                         lru_start,
    output logic [SET_INDEX-1:0]         lru_index,
    output logic [4:0]                   lru_way_index,
    output logic                         lru_found,
    output logic                         lru_updated,
    output logic                         lru_replace,
    input  logic                         lru_done,
    input  logic                         lru_block_replace,
    input  logic [4:0]                   lru_replace_index
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DW = $clog2(WAY + 3);
    localparam int BW = $clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] DRAIN_INIT   = DW'(WAY + 2);
    localparam logic [BW-1:0] TIMEOUT_LAST = BW'(TIMEOUT - 1);

    lru_arb_state_e       state_q, state_d;
    logic [IW-1:0]        rr_ptr;
    logic [NUM_REQ-1:0]   gnt_oh_q;
    logic [DW-1:0]        drain_cnt;
    logic [BW-1:0]        bsy_cnt;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [IW-1:0]        arb_id;
    logic                 arb_any;
    logic                 do_grant, do_done, do_timeout;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr_arbiter (
        .req      (req),
        .ptr      (rr_ptr),
        .grant    (arb_grant),
        .grant_id (arb_id),
        .any      (arb_any)
    );

    always_comb begin
        state_d    = state_q;
        do_grant   = 1'b0;
        do_done    = 1'b0;
        do_timeout = 1'b0;
        case (state_q)
            ST_DRAIN: begin
                if (drain_cnt <= DW'(1)) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (arb_any) begin
                    do_grant = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_BUSY;
            ST_BUSY: begin
                if (lru_done) begin
                    do_done = 1'b1;
                    state_d = ST_RESP;
                end else if (bsy_cnt == TIMEOUT_LAST) begin
                    do_timeout = 1'b1;
                    state_d    = ST_DRAIN;
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_DRAIN;
        endcase
    end

    // Operands stay frozen from grant until RESP/DRAIN: the engine rereads them every iteration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= ST_DRAIN;
            rr_ptr            <= '0;
            gnt_oh_q          <= '0;
            drain_cnt         <= DRAIN_INIT;
            bsy_cnt           <= '0;
            ack               <= '0;
            rsp_replace_index <= '0;
            rsp_block_replace <= 1'b0;
            rsp_timeout       <= 1'b0;
            err_sticky        <= 1'b0;
            lru_start         <= 1'b0;
            lru_index         <= '0;
            lru_way_index     <= '0;
            lru_found         <= 1'b0;
            lru_updated       <= 1'b0;
            lru_replace       <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_DRAIN, ST_RESP: begin
                    ack               <= '0;
                    rsp_replace_index <= '0;
                    rsp_block_replace <= 1'b0;
                    rsp_timeout       <= 1'b0;
                    lru_index         <= '0;
                    lru_way_index     <= '0;
                    lru_found         <= 1'b0;
                    lru_updated       <= 1'b0;
                    lru_replace       <= 1'b0;
                    if (state_q == ST_DRAIN) begin
                        drain_cnt <= (drain_cnt <= DW'(1)) ? '0 : drain_cnt - DW'(1);
                    end
                end
                ST_IDLE: begin
                    if (do_grant) begin
                        gnt_oh_q      <= arb_grant;
                        lru_start     <= 1'b1;
                        lru_index     <= req_index[int'(arb_id)*SET_INDEX +: SET_INDEX];
                        lru_way_index <= req_way_index[int'(arb_id)*5 +: 5];
                        lru_found     <= req_found[arb_id];
                        lru_updated   <= req_updated[arb_id];
                        lru_replace   <= req_replace[arb_id];
                        rr_ptr        <= (int'(arb_id) == NUM_REQ - 1) ? '0 : arb_id + IW'(1);
                    end
                end
                ST_ISSUE: begin
                    lru_start <= 1'b0;
                    bsy_cnt   <= '0;
                end
                ST_BUSY: begin
                    if (do_done) begin
                        ack               <= gnt_oh_q;
                        rsp_block_replace <= lru_block_replace;
                        rsp_replace_index <= lru_block_replace ? lru_replace_index : 5'd0;
                    end else if (do_timeout) begin
                        ack               <= gnt_oh_q;
                        rsp_timeout       <= 1'b1;
                        err_sticky        <= 1'b1;
                        rsp_block_replace <= 1'b0;
                        rsp_replace_index <= '0;
                        drain_cnt         <= DRAIN_INIT;
                    end else begin
                        bsy_cnt <= bsy_cnt + BW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/lru_update_arbiter.md
Name: lru_update_arbiter

Overview:
- Shares one `lru` replacement-state engine among NUM_REQ per-core cache controllers in the multicore simulator.
- Each requester asks for one of three operations: a hit-touch, a fill-into-empty update, or a victim selection.
- The block round-robin arbitrates, issues a single-cycle start, and holds the engine operands stable while the engine walks the ways.
- It returns the victim way and the completion to the granted requester, and it guards against a hung engine and against reset landing while the engine is in flight.

Parameters:
- NUM_REQ, 4, number of requesting cores (2..8).
- WAY, 4, associativity; must equal the engine's `way`.
- BLOCK_SIZE_BYTE, 16, block size; sets the SET_INDEX derivation.
- CACHE_SIZE_BYTE, 32768, cache size.
- SET_INDEX, log2(CACHE_SIZE_BYTE/(BLOCK_SIZE_BYTE*WAY)), derived set-index width (9 at defaults).
- TIMEOUT, 64, maximum cycles spent in BUSY before abort.

Ports:
- clk in 1: clock.
- rst in 1: reset, asynchronous, active-high.
- req in NUM_REQ: per-core request. Held high with stable operands until ack.
- req_index in NUM_REQ*SET_INDEX: per-core set index, packed with core 0 in the LSBs.
- req_way_index in NUM_REQ*5: per-core hit way, 1-based (1..WAY).
- req_found in NUM_REQ: hit-touch command.
- req_updated in NUM_REQ: fill into an empty way.
- req_replace in NUM_REQ: set is full, select a victim.
- ack out NUM_REQ: one-hot completion pulse, 1 cycle.
- rsp_replace_index out 5: victim way (0-based), valid when ack is high.
- rsp_block_replace out 1: victim is valid, qualified by ack.
- rsp_timeout out 1: operation aborted, qualified by ack.
- err_sticky out 1: a timeout has occurred since reset.
- lru_start out 1: to engine `start`.
- lru_index out SET_INDEX: to engine `index`.
- lru_way_index out 5: to engine `way_index`.
- lru_found out 1: to engine `found_in_cache`.
- lru_updated out 1: to engine `updated`.
- lru_replace out 1: to engine `replace`.
- lru_done in 1: from engine `update_lru`.
- lru_block_replace in 1: from engine `block_replace`.
- lru_replace_index in 5: from engine `replace_index`.

Behaviour:
- Reset values: all outputs 0, rr_ptr=0, state=DRAIN, drain_cnt=WAY+2.
- All outputs are registered.

States:
- DRAIN: the engine has no reset, so an operation may still be in flight when rst releases.
  - No grants while in DRAIN.
  - drain_cnt decrements each cycle; on reaching 0, go to IDLE.
- IDLE: if any req bit is set, grant the first set bit at or after rr_ptr (cyclic).
  - Capture that core's index, way_index and command bits into the lru_* outputs.
  - Set lru_start=1 and go to ISSUE.
  - rr_ptr <= grant+1, wrapping to 0 at NUM_REQ.
- ISSUE: lru_start is high for exactly this one cycle; the engine samples it on the closing edge.
  - Clear lru_start, clear bsy_cnt, go to BUSY.
- BUSY: lru_index, lru_way_index and the command bits stay frozen, because the engine reads them on every iteration.
  - If lru_done=1: capture lru_replace_index and lru_block_replace into the rsp_* outputs, set ack[grant]=1, go to RESP.
  - Else, if bsy_cnt==TIMEOUT-1: set ack[grant]=1, rsp_timeout=1, err_sticky=1, rsp_block_replace=0, go to DRAIN with drain_cnt=WAY+2.
  - Else bsy_cnt increments.
- RESP: ack and rsp_* are valid this cycle only. The engine returns to idle at this same edge.
  - Clear ack, rsp_timeout and lru_* commands; go to IDLE.
  - The RESP cycle is the mandatory one-cycle gap before the next lru_start.

Latency:
- From req seen in IDLE to ack is WAY+3 cycles: grant edge, start edge, WAY engine iterations, then done capture.
- Back-to-back throughput is one operation per WAY+4 cycles.

Boundary conditions:
- Simultaneous requests: exactly one grant per IDLE cycle, strict round-robin, so no core waits more than NUM_REQ-1 operations.
- A req deasserted before ack is a protocol violation. The captured operation still completes and ack is still pulsed.
- The command bits are forwarded unmodified.
  - Engine priority: found, then !found&&updated, then !updated&&replace.
  - An all-zero command never raises lru_done and therefore times out.
- rst asserted in ISSUE or BUSY: all outputs clear immediately and state goes to DRAIN.
  - The engine may finish on zeroed operands, which touches set 0. This is an accepted simulator artefact.
- rsp_replace_index is meaningful only when rsp_block_replace=1. Otherwise it is 0.

Decomposition:
- Shared package (`cache_pkg`):
  - SET_INDEX and way-width derivation functions, shared with the engine.
  - State encoding constants DRAIN/IDLE/ISSUE/BUSY/RESP.
  - Command bit positions.
- One natural sub-module: `rr_arbiter`, a combinational round-robin priority pick from req and rr_ptr. It outputs a one-hot grant and a binary grant id, with a unit test of its own.

Test Plan:
- After reset, hold req=0001 (found, index=5, way_index=2) during DRAIN → no lru_start until WAY+2 cycles have elapsed; then ack[0] arrives WAY+3 cycles after the grant, with rsp_block_replace=0.
- Single replace: req=0010 (replace, index=7) with the engine's set-7 counters at reset order → ack[1], rsp_block_replace=1, rsp_replace_index=0. A repeat of the same request gives rsp_replace_index=1.
- All four cores request at once, each holding until its ack → acks in order 0,1,2,3, with exactly one lru_start per operation and no two lru_start pulses closer than WAY+4 cycles.
- Starvation check: core 0 re-requests immediately after every ack while core 3 holds req → core 3 is acked within 4 operations.
- Stub engine that never raises done → after TIMEOUT cycles, ack with rsp_timeout=1 and err_sticky=1; the next grant follows only after WAY+2 drain cycles.
- Assert rst for 1 cycle mid-BUSY → outputs clear asynchronously and ack never pulses for the aborted operation; a new request completes normally after the drain.
